// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single borrow flop; results are held until the next operation completes.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             dbit, br_nxt, last;

  assign dbit   = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = (state == RUN);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa  <= a;
          sb  <= b;
          br  <= bin;
          cnt <= '0;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          acc <= {dbit, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          // br here is the borrow into the MSB; br_nxt is the borrow out of it
          if (last) begin
            d    <= {dbit, acc[WIDTH-1:1]};
            bout <= br_nxt;
            ovf  <= br ^ br_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
